// File: rtl/regs.sv
// regs: 32 x 32-bit architectural register file with two operand read ports,
// a stored-value debug port and a committed-write counter. Define REGS_BYPASS_EN to forward same-cycle write data.
module regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  reg_waddr_i,
  input  logic [31:0] reg_wdata_i,
  input  logic        reg_wen_i,
  input  logic [4:0]  reg1_raddr_i,
  input  logic [4:0]  reg2_raddr_i,
  output logic [31:0] reg1_rdata_o,
  output logic [31:0] reg2_rdata_o,
  input  logic [4:0]  dbg_raddr_i,
  output logic [31:0] dbg_rdata_o,
  output logic [31:0] wr_cnt_o
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] wr_cnt_q;
  logic [31:0] wr_cnt_d;
  logic        wr_commit;

  // Gating on rst_n here also drops reset-cycle writes and suppresses bypass during reset.
  assign wr_commit = rst_n && reg_wen_i && (reg_waddr_i != 5'd0);

  always_comb begin
    regs_d   = regs_q;
    wr_cnt_d = wr_cnt_q;
    if (wr_commit) begin
      regs_d[reg_waddr_i] = reg_wdata_i;
      wr_cnt_d            = wr_cnt_q + 32'd1;
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      wr_cnt_q <= '0;
    end else begin
      regs_q   <= regs_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  // Reads depend only on inputs and stored state, never on another output.
  always_comb begin
    reg1_rdata_o = '0;
    reg2_rdata_o = '0;
    dbg_rdata_o  = '0;
    if (rst_n) begin
      if (reg1_raddr_i != 5'd0) reg1_rdata_o = regs_q[reg1_raddr_i];
      if (reg2_raddr_i != 5'd0) reg2_rdata_o = regs_q[reg2_raddr_i];
      if (dbg_raddr_i  != 5'd0) dbg_rdata_o  = regs_q[dbg_raddr_i];
`ifdef REGS_BYPASS_EN
      if (wr_commit && (reg_waddr_i == reg1_raddr_i)) reg1_rdata_o = reg_wdata_i;
      if (wr_commit && (reg_waddr_i == reg2_raddr_i)) reg2_rdata_o = reg_wdata_i;
`endif
    end
  end

  assign wr_cnt_o = wr_cnt_q;

endmodule

// File: tb/tb_regs.sv
// tb_regs: scoreboard bench for regs; expectations come from a bench-side register model.
module tb_regs;

`ifdef REGS_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  reg_waddr_i = '0;
  logic [31:0] reg_wdata_i = '0;
  logic        reg_wen_i = 1'b0;
  logic [4:0]  reg1_raddr_i = '0;
  logic [4:0]  reg2_raddr_i = '0;
  logic [31:0] reg1_rdata_o;
  logic [31:0] reg2_rdata_o;
  logic [4:0]  dbg_raddr_i = '0;
  logic [31:0] dbg_rdata_o;
  logic [31:0] wr_cnt_o;

  logic [31:0] mdl [32];
  logic [31:0] mdl_cnt = '0;
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  regs dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .reg_waddr_i  (reg_waddr_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_wen_i    (reg_wen_i),
    .reg1_raddr_i (reg1_raddr_i),
    .reg2_raddr_i (reg2_raddr_i),
    .reg1_rdata_o (reg1_rdata_o),
    .reg2_rdata_o (reg2_rdata_o),
    .dbg_raddr_i  (dbg_raddr_i),
    .dbg_rdata_o  (dbg_rdata_o),
    .wr_cnt_o     (wr_cnt_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp_ok);
    if (!rst_n) return 32'h0;
    if (byp_ok && BYP && reg_wen_i && (reg_waddr_i != 5'd0) && (reg_waddr_i == a))
      return reg_wdata_i;
    if (a == 5'd0) return 32'h0;
    return mdl[a];
  endfunction

  task automatic drive(input logic r, input logic w, input logic [4:0] a, input logic [31:0] d,
                       input logic [4:0] p1, input logic [4:0] p2, input logic [4:0] db);
    rst_n        = r;
    reg_wen_i    = w;
    reg_waddr_i  = a;
    reg_wdata_i  = d;
    reg1_raddr_i = p1;
    reg2_raddr_i = p2;
    dbg_raddr_i  = db;
  endtask

  // Advance one rising edge and apply the same edge to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
      mdl_cnt = 32'h0;
    end else if (reg_wen_i && (reg_waddr_i != 5'd0)) begin
      mdl[reg_waddr_i] = reg_wdata_i;
      mdl_cnt = mdl_cnt + 32'd1;
    end
    #1;
  endtask

  task automatic test_reset();
    logic [31:0] e;
    drive(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd5, 5'd5);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (reg1_rdata_o !== e) begin errors++; $display("FAIL rst_p1 got %h exp %h", reg1_rdata_o, e); end
    e = exp_q.pop_front(); checks++;
    if (dbg_rdata_o !== e) begin errors++; $display("FAIL rst_dbg got %h exp %h", dbg_rdata_o, e); end
    tick();
    tick();
    drive(1'b1, 1'b0, 5'd5, 32'h0, 5'd5, 5'd5, 5'd5);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (reg1_rdata_o !== e) begin errors++; $display("FAIL post_rst_x5 got %h exp %h", reg1_rdata_o, e); end
    e = exp_q.pop_front(); checks++;
    if (dbg_rdata_o !== e) begin errors++; $display("FAIL post_rst_dbg_x5 got %h exp %h", dbg_rdata_o, e); end
    e = exp_q.pop_front(); checks++;
    if (wr_cnt_o !== e) begin errors++; $display("FAIL post_rst_cnt got %h exp %h", wr_cnt_o, e); end
    tick();
  endtask

  task automatic test_write_read();
    logic [31:0] e;
    drive(1'b1, 1'b1, 5'd3, 32'h1234_5678, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd3, 32'h0, 5'd3, 5'd3, 5'd3);
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'd1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (reg1_rdata_o !== e) begin errors++; $display("FAIL wr_p1 got %h exp %h", reg1_rdata_o, e); end
    e = exp_q.pop_front(); checks++;
    if (reg2_rdata_o !== e) begin errors++; $display("FAIL wr_p2 got %h exp %h", reg2_rdata_o, e); end
    e = exp_q.pop_front(); checks++;
    if (dbg_rdata_o !== e) begin errors++; $display("FAIL wr_dbg got %h exp %h", dbg_rdata_o, e); end
    e = exp_q.pop_front(); checks++;
    if (wr_cnt_o !== e) begin errors++; $display("FAIL wr_cnt got %h exp %h", wr_cnt_o, e); end
    tick();
  endtask

  task automatic test_x0();
    logic [31:0] e;
    logic [31:0] cnt0;
    cnt0 = mdl_cnt;
    drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (reg1_rdata_o !== e) begin errors++; $display("FAIL x0_same_cycle_p1 got %h exp %h", reg1_rdata_o, e); end
    e = exp_q.pop_front(); checks++;
    if (reg2_rdata_o !== e) begin errors++; $display("FAIL x0_same_cycle_p2 got %h exp %h", reg2_rdata_o, e); end
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(cnt0);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (reg1_rdata_o !== e) begin errors++; $display("FAIL x0_p1 got %h exp %h", reg1_rdata_o, e); end
    e = exp_q.pop_front(); checks++;
    if (dbg_rdata_o !== e) begin errors++; $display("FAIL x0_dbg got %h exp %h", dbg_rdata_o, e); end
    e = exp_q.pop_front(); checks++;
    if (wr_cnt_o !== e) begin errors++; $display("FAIL x0_cnt got %h exp %h", wr_cnt_o, e); end
    tick();
  endtask

  task automatic test_bypass();
    logic [31:0] e;
    drive(1'b1, 1'b1, 5'd7, 32'h1111_2222, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd7, 5'd7);
    exp_q.push_back(BYP ? 32'hA5A5_A5A5 : 32'h1111_2222);
    exp_q.push_back(BYP ? 32'hA5A5_A5A5 : 32'h1111_2222);
    exp_q.push_back(32'h1111_2222);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (reg1_rdata_o !== e) begin errors++; $display("FAIL byp_p1 got %h exp %h", reg1_rdata_o, e); end
    e = exp_q.pop_front(); checks++;
    if (reg2_rdata_o !== e) begin errors++; $display("FAIL byp_p2 got %h exp %h", reg2_rdata_o, e); end
    e = exp_q.pop_front(); checks++;
    if (dbg_rdata_o !== e) begin errors++; $display("FAIL byp_dbg_old got %h exp %h", dbg_rdata_o, e); end
    tick();
    drive(1'b1, 1'b0, 5'd7, 32'h0, 5'd7, 5'd7, 5'd7);
    exp_q.push_back(32'hA5A5_A5A5);
    exp_q.push_back(32'hA5A5_A5A5);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (reg1_rdata_o !== e) begin errors++; $display("FAIL byp_next_p1 got %h exp %h", reg1_rdata_o, e); end
    e = exp_q.pop_front(); checks++;
    if (dbg_rdata_o !== e) begin errors++; $display("FAIL byp_next_dbg got %h exp %h", dbg_rdata_o, e); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic [4:0]  wa;
    logic [4:0]  p1;
    logic [4:0]  p2;
    for (int n = 0; n < 200; n++) begin
      wa = 5'($urandom_range(0, 31));
      p1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
      p2 = ($urandom_range(0, 3) == 0) ? p1 : 5'($urandom_range(0, 31));
      drive(1'b1, 1'($urandom_range(0, 1)), wa, $urandom, p1, p2, 5'($urandom_range(0, 31)));
      exp_q.push_back(exp_read(reg1_raddr_i, 1'b1));
      exp_q.push_back(exp_read(reg2_raddr_i, 1'b1));
      exp_q.push_back(exp_read(dbg_raddr_i, 1'b0));
      exp_q.push_back(mdl_cnt);
      @(negedge clk);
      e = exp_q.pop_front(); checks++;
      if (reg1_rdata_o !== e) begin errors++; $display("FAIL b2b_p1 n=%0d got %h exp %h", n, reg1_rdata_o, e); end
      e = exp_q.pop_front(); checks++;
      if (reg2_rdata_o !== e) begin errors++; $display("FAIL b2b_p2 n=%0d got %h exp %h", n, reg2_rdata_o, e); end
      e = exp_q.pop_front(); checks++;
      if (dbg_rdata_o !== e) begin errors++; $display("FAIL b2b_dbg n=%0d got %h exp %h", n, dbg_rdata_o, e); end
      e = exp_q.pop_front(); checks++;
      if (wr_cnt_o !== e) begin errors++; $display("FAIL b2b_cnt n=%0d got %h exp %h", n, wr_cnt_o, e); end
      tick();
    end
  endtask

  task automatic test_wrap();
    logic [31:0] e;
    drive(1'b1, 1'b0, 5'd9, 32'h0, 5'd0, 5'd0, 5'd0);
    force dut.wr_cnt_d = 32'hFFFF_FFFF;
    tick();
    release dut.wr_cnt_d;
    mdl_cnt = 32'hFFFF_FFFF;
    exp_q.push_back(32'hFFFF_FFFF);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (wr_cnt_o !== e) begin errors++; $display("FAIL wrap_preload got %h exp %h", wr_cnt_o, e); end
    tick();
    drive(1'b1, 1'b1, 5'd9, 32'h0BAD_F00D, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd9, 32'h0, 5'd9, 5'd0, 5'd0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h0BAD_F00D);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (wr_cnt_o !== e) begin errors++; $display("FAIL wrap_cnt got %h exp %h", wr_cnt_o, e); end
    e = exp_q.pop_front(); checks++;
    if (reg1_rdata_o !== e) begin errors++; $display("FAIL wrap_x9 got %h exp %h", reg1_rdata_o, e); end
    tick();
  endtask

  task automatic test_reset_clear();
    logic [31:0] e;
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, 1'b1, 5'(i), 32'(i), 5'd0, 5'd0, 5'd0);
      tick();
    end
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd17, 5'd31, 5'd1);
    exp_q.push_back(32'd17);
    exp_q.push_back(32'd31);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (reg1_rdata_o !== e) begin errors++; $display("FAIL fill_x17 got %h exp %h", reg1_rdata_o, e); end
    e = exp_q.pop_front(); checks++;
    if (reg2_rdata_o !== e) begin errors++; $display("FAIL fill_x31 got %h exp %h", reg2_rdata_o, e); end
    tick();
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 5'd0);
    for (int a = 0; a < 32; a++) begin
      dbg_raddr_i = 5'(a);
      exp_q.push_back(32'h0);
      #1;
      e = exp_q.pop_front(); checks++;
      if (dbg_rdata_o !== e) begin errors++; $display("FAIL clear_dbg x%0d got %h exp %h", a, dbg_rdata_o, e); end
    end
    exp_q.push_back(32'h0);
    e = exp_q.pop_front(); checks++;
    if (wr_cnt_o !== e) begin errors++; $display("FAIL clear_cnt got %h exp %h", wr_cnt_o, e); end
    tick();
  endtask

  task automatic test_reset_release();
    logic [31:0] e;
    drive(1'b0, 1'b1, 5'd12, 32'hCAFE_0012, 5'd0, 5'd0, 5'd0);
    tick();
    rst_n = 1'b1;
    tick();
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd12, 5'd0, 5'd12);
    exp_q.push_back(32'hCAFE_0012);
    exp_q.push_back(32'hCAFE_0012);
    exp_q.push_back(32'd1);
    @(negedge clk);
    e = exp_q.pop_front(); checks++;
    if (reg1_rdata_o !== e) begin errors++; $display("FAIL rel_p1 got %h exp %h", reg1_rdata_o, e); end
    e = exp_q.pop_front(); checks++;
    if (dbg_rdata_o !== e) begin errors++; $display("FAIL rel_dbg got %h exp %h", dbg_rdata_o, e); end
    e = exp_q.pop_front(); checks++;
    if (wr_cnt_o !== e) begin errors++; $display("FAIL rel_cnt got %h exp %h", wr_cnt_o, e); end
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    #1;
    test_reset();
    test_write_read();
    test_x0();
    test_bypass();
    test_back_to_back();
    test_wrap();
    test_reset_clear();
    test_reset_release();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regs.md
REGS -- requirements
Module: regs

Interface
REQ-001 The block SHALL have no parameters: data width fixed at 32 bits, register address fixed at 5 bits, 32 architectural registers x0..x31.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 The block SHALL have port reg_waddr_i, input, 5 bits: write-back destination from execute stage rd_addr_o.
REQ-005 The block SHALL have port reg_wdata_i, input, 32 bits: write-back data from execute stage rd_data_o.
REQ-006 The block SHALL have port reg_wen_i, input, 1 bit: write enable from execute stage rd_wen_o.
REQ-007 The block SHALL have port reg1_raddr_i, input, 5 bits: decode-stage rs1 read address.
REQ-008 The block SHALL have port reg2_raddr_i, input, 5 bits: decode-stage rs2 read address.
REQ-009 The block SHALL have port reg1_rdata_o, output, 32 bits: rs1 read data, combinational.
REQ-010 The block SHALL have port reg2_rdata_o, output, 32 bits: rs2 read data, combinational.
REQ-011 The block SHALL have port dbg_raddr_i, input, 5 bits: debug/testbench read address.
REQ-012 The block SHALL have port dbg_rdata_o, output, 32 bits: debug read data, stored value only, never bypassed.
REQ-013 The block SHALL have port wr_cnt_o, output, 32 bits: count of committed architectural writes.

Function
REQ-014 A write SHALL commit at the rising edge when rst_n=1, reg_wen_i=1 and reg_waddr_i!=0; registers[reg_waddr_i] takes reg_wdata_i.
REQ-015 Writes addressed to x0 SHALL be discarded; x0 SHALL always read 32'h0 on every read port.
REQ-016 Read ports SHALL be purely combinational from address to data: zero-cycle latency.
REQ-017 Read ports 1 and 2 SHALL be independent; identical addresses on both ports SHALL return identical data.
REQ-018 wr_cnt_o SHALL increment by 1 on each committed write per REQ-014, SHALL not increment on x0 or disabled writes, and SHALL wrap from 32'hFFFF_FFFF to 32'h0.
REQ-019 One write and three reads in the same cycle SHALL be supported without stall; the block SHALL have no backpressure.
REQ-020 reg_waddr_i and reg_wdata_i SHALL be ignored while reg_wen_i=0, whatever their values.
REQ-021 No read port output SHALL depend combinationally on another output of this block, so no logic loop forms through the execute stage.

Reset
REQ-022 At a rising edge with rst_n=0, all registers x1..x31 SHALL clear to 32'h0 and wr_cnt_o SHALL clear to 32'h0.
REQ-023 A write presented in a reset cycle SHALL be dropped and SHALL not be counted.
REQ-024 While rst_n=0, reg1_rdata_o, reg2_rdata_o and dbg_rdata_o SHALL read 32'h0, and bypass SHALL be suppressed.
REQ-025 When reset is released mid-stream, the first write SHALL commit at the first rising edge with rst_n=1.

Configuration
REQ-026 Macro REGS_BYPASS_EN SHALL select write-to-read bypass.
REQ-027 With REGS_BYPASS_EN defined: when reg_wen_i=1, reg_waddr_i!=0 and reg_waddr_i equals a port-1 or port-2 read address, that port SHALL return reg_wdata_i in the same cycle.
REQ-028 Without REGS_BYPASS_EN: read ports SHALL return the stored value, so the new value is visible from the cycle after commit.
REQ-029 Under either setting, the dbg port and wr_cnt_o behaviour SHALL be identical.

Verification
REQ-030 Scenario: hold rst_n=0 for 2 cycles with wen=1, waddr=5, wdata=32'hDEAD_BEEF, then read x5 -> read returns 32'h0 and wr_cnt_o=0.
REQ-031 Scenario: write x3=32'h1234_5678; next cycle read port1=3, port2=3, dbg=3 -> all three return 32'h1234_5678 and wr_cnt_o=1.
REQ-032 Scenario: write x0=32'hFFFF_FFFF, then read x0 on all ports -> all return 32'h0 and wr_cnt_o is unchanged.
REQ-033 Scenario: in the same cycle write x7=32'hA5A5_A5A5 and set port1=7. With REGS_BYPASS_EN, port1 returns 32'hA5A5_A5A5 and dbg=7 returns the old value. Without REGS_BYPASS_EN, port1 returns the old value, then 32'hA5A5_A5A5 one cycle later.
REQ-034 Scenario: force the counter to 32'hFFFF_FFFF by 2^32-1 writes or by a backdoor preload, then commit one write -> wr_cnt_o=32'h0.
REQ-035 Scenario: write x1..x31 with value=index, assert rst_n=0 for 1 cycle, then sweep dbg_raddr_i over 0..31 -> every read returns 32'h0.
